mem_port_arbiter: RTL

Shares the core's single memory port between instruction fetch and the execute stage's load/store path. It arbitrates the two requesters, runs one memory transaction at a time through a small state machine, and returns a registered acknowledge and read data to the winner. Execute consumes `dm_rdata` as its load data word for sign/zero extension; fetch consumes `if_rdata` as the next instruction.

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store,
// one transaction at a time. Define ARB_FAIR_EN to add the fetch-starvation guard.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int FAIR_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ack,
  output logic [XLEN-1:0] if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  input  logic [3:0]      dm_be,
  output logic            dm_ack,
  output logic [XLEN-1:0] dm_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [XLEN-1:0]   mem_addr_reg, mem_addr_next;
  logic [XLEN-1:0]   mem_wdata_reg, mem_wdata_next;
  logic [3:0]        mem_be_reg, mem_be_next;
  logic              if_ack_reg, if_ack_next;
  logic              dm_ack_reg, dm_ack_next;
  logic [XLEN-1:0]   if_rdata_reg, if_rdata_next;
  logic [XLEN-1:0]   dm_rdata_reg, dm_rdata_next;

  logic              is_idle;
  logic              if_eligible;
  logic              dm_eligible;
  logic              fetch_forced;
  logic              grant_if;
  logic              grant_dm;

  // A requester still holding req during its own ack cycle is finishing, not asking again.
  assign is_idle     = (state_reg == IDLE);
  assign if_eligible = if_req & ~if_ack_reg;
  assign dm_eligible = dm_req & ~dm_ack_reg;
  assign grant_if    = is_idle & if_eligible & (~dm_eligible | fetch_forced);
  assign grant_dm    = is_idle & dm_eligible & ~grant_if;

`ifdef ARB_FAIR_EN
  localparam logic [3:0] FAIR_LIMIT_C = 4'(FAIR_LIMIT);

  logic [3:0] fair_cnt_reg, fair_cnt_next;

  assign fetch_forced = (fair_cnt_reg == FAIR_LIMIT_C);

  // Counts data grants that overtook a waiting fetch; any fetch grant clears it.
  always_comb begin
    fair_cnt_next = fair_cnt_reg;
    if (grant_if) begin
      fair_cnt_next = '0;
    end else if (grant_dm && if_eligible && (fair_cnt_reg != 4'hF)) begin
      fair_cnt_next = fair_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fair_cnt_reg <= '0;
    end else begin
      fair_cnt_reg <= fair_cnt_next;
    end
  end
`else
  logic unused_fair_limit;

  assign fetch_forced      = 1'b0;
  assign unused_fair_limit = (FAIR_LIMIT != 0);
`endif

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_be_next    = mem_be_reg;
    if_ack_next    = 1'b0;
    dm_ack_next    = 1'b0;
    if_rdata_next  = if_rdata_reg;
    dm_rdata_next  = dm_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (grant_if) begin
          // Fetch never writes: force a full-word read.
          state_next     = BUSY_IF;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = if_addr;
          mem_wdata_next = '0;
          mem_be_next    = 4'hF;
        end else if (grant_dm) begin
          state_next     = BUSY_DM;
          mem_req_next   = 1'b1;
          mem_we_next    = dm_we;
          mem_addr_next  = dm_addr;
          mem_wdata_next = dm_wdata;
          mem_be_next    = dm_be;
        end
      end

      BUSY_IF: begin
        if (mem_ready) begin
          state_next    = IDLE;
          mem_req_next  = 1'b0;
          if_rdata_next = mem_rdata;
          if_ack_next   = 1'b1;
        end
      end

      BUSY_DM: begin
        if (mem_ready) begin
          state_next    = IDLE;
          mem_req_next  = 1'b0;
          dm_rdata_next = mem_we_reg ? '0 : mem_rdata;
          dm_ack_next   = 1'b1;
        end
      end

      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      if_ack_reg    <= 1'b0;
      dm_ack_reg    <= 1'b0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_be_reg    <= mem_be_next;
      if_ack_reg    <= if_ack_next;
      dm_ack_reg    <= dm_ack_next;
      if_rdata_reg  <= if_rdata_next;
      dm_rdata_reg  <= dm_rdata_next;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_be    = mem_be_reg;
  assign if_ack    = if_ack_reg;
  assign dm_ack    = dm_ack_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_rdata  = dm_rdata_reg;
  assign busy      = ~is_idle;

endmodule
